band_power_window: RTL
======================

Name: band_power_window

Overview:
- Downstream consumer of the 2nd-order bandpass filter output.
- Computes windowed mean-square (band power) of the filtered signed sample stream over non-overlapping windows of 2^WIN_LOG2 samples.
- Presents each result on a valid/ready output port. It is the power-spectrum feature source for the per-band detection logic.
- Accumulation runs gap-free, so no input samples are lost while a result waits for the consumer.

Parameters:
- DATA_W, 32: input sample width, signed two's complement. Matches the filter's y output.
- WIN_LOG2, 8: log2 of the window length in samples (256 by default). Legal range is 1..16.
- ACC_W, 2*DATA_W+WIN_LOG2: accumulator width. Guarantees no wrap within a window.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset. Asserting low clears all state immediately; release is synchronised externally.
- clear, input, 1: synchronous window restart, active-high.
- in_valid, input, 1: in_data carries a new sample this cycle.
- in_data, input, DATA_W: filtered sample, signed.
- out_valid, output, 1: out_power holds an unconsumed result.
- out_ready, input, 1: consumer accepts the result.
- out_power, output, 2*DATA_W: mean square of the last completed window, unsigned.
- overrun, output, 1: sticky flag. A completed window was dropped because the previous result was still pending.

Behaviour:
- Reset (reset=0): all outputs are 0; the accumulator, sample counter and pipeline valids are 0. out_power=0, out_valid=0, overrun=0.
- Stage 1, on a cycle with in_valid=1: sq_r <= in_data*in_data, computed signed and stored as an unsigned 2*DATA_W value. sq_v <= in_valid.
- Stage 2, when sq_v=1: acc <= acc + zero-extended sq_r, and cnt <= cnt+1 (WIN_LOG2-bit counter).
  - When cnt == 2^WIN_LOG2-1 and sq_v=1, the window completes.
  - On completion, the result candidate is (acc + sq_r) >>> WIN_LOG2, truncated to 2*DATA_W. This never loses information, because mean square ≤ 2^(2*DATA_W-2).
  - On completion, acc <= 0 and cnt wraps to 0 in the same cycle. The next window's first sample accumulates from the following sq_v.
- Latency: the last window sample is accepted at edge k; out_valid rises after edge k+2.
- Output handshake:
  - out_valid stays high and out_power stays stable until a cycle with out_valid=1 and out_ready=1. out_valid clears on that edge.
  - When a window completes on the same edge a pending result is consumed, the new result loads and out_valid stays 1.
  - When a window completes while out_valid=1 and out_ready=0, the new result is discarded, out_power is unchanged, and overrun <= 1.
  - overrun is cleared only by reset.
- in_valid gaps are legal: the counter advances only on valid samples. in_valid has no ready; the block always accepts.
- clear=1 forces, on the next edge: acc=0, cnt=0, sq_v=0.
  - Any sample presented in the same cycle is discarded.
  - A pending out_valid/out_power is kept and remains consumable.
  - overrun is unaffected.
- Reset asserted mid-window or mid-handshake: immediate return to reset values. A partial window is lost.

Decomposition:
- Shared package filter_pkg: DATA_W, the coefficient scale shift (20) shared with the filter, default WIN_LOG2 per band, and the result width constant.
- One sub-module, sq_stage: registered signed squarer with valid pipe and clear. It keeps the multiplier isolated for DSP mapping.
- Counter, accumulator and output register stay in band_power_window.

Test Plan:
- WIN_LOG2=2, four valid samples of +1000, out_ready=1 → out_valid pulses for 1 cycle, 2 edges after the 4th sample; out_power=1000000; overrun=0.
- WIN_LOG2=2, samples -3,5,-7,1 with in_valid toggling every other cycle → out_power=(9+25+49+1)>>2=21.
- WIN_LOG2=2, four samples of -2^31 → out_power=2^62, with no wrap.
- out_ready=0 across two full windows (values 4 then 8) → out_power stays 16 and overrun=1. Then out_ready=1 → one acceptance of 16; out_valid low afterwards.
- clear asserted after 2 samples of a window, together with a 3rd valid sample → that sample is ignored; the next 4 samples of 10 give out_power=100.
- reset driven low asynchronously between clock edges while out_valid=1 → out_valid, out_power and overrun read 0 before the next rising edge.

Source files
------------

// File: rtl/filter_pkg.sv
// filter_pkg
// Constants shared between the bandpass filter and its downstream band-power
// consumers. No ports; imported by band_power_window and sq_stage.
//   FILT_DATA_W      : filter output sample width (signed)
//   COEF_SHIFT       : fixed-point scale shift of the filter coefficients
//   WIN_LOG2_DEFAULT : default log2 window length for every band
//   FILT_POWER_W     : width of a mean-square result
//   acc_width()      : accumulator width that cannot wrap within a window
package filter_pkg;

    localparam int unsigned FILT_DATA_W      = 32;
    localparam int unsigned COEF_SHIFT       = 20;
    localparam int unsigned WIN_LOG2_DEFAULT = 8;
    localparam int unsigned FILT_POWER_W     = 2 * FILT_DATA_W;

    // A square needs 2*data_w bits; summing 2^win_log2 of them adds win_log2 bits.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned win_log2);
        return 2 * data_w + win_log2;
    endfunction

endpackage

// File: rtl/sq_stage.sv
// sq_stage
// Registered signed squarer with a valid pipe. Kept as its own module so the
// multiplier maps cleanly onto a DSP block.
// Ports:
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   clear    : synchronous restart, drops the sample presented this cycle
//   in_valid : in_data carries a sample
//   in_data  : signed sample
//   sq_valid : sq_data holds the square of an accepted sample
//   sq_data  : in_data * in_data, unsigned
module sq_stage
    import filter_pkg::*;
#(
    parameter int unsigned DATA_W = FILT_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   in_data,
    output logic                       sq_valid,
    output logic        [2*DATA_W-1:0] sq_data
);

    logic signed [2*DATA_W-1:0] ext;
    logic signed [2*DATA_W-1:0] prod;
    logic                       sq_v_q;
    logic        [2*DATA_W-1:0] sq_q;

    // Sign-extend first so the product is formed at full width; the square of
    // the most negative value (2^(2*DATA_W-2)) still fits.
    always_comb begin
        ext  = {{DATA_W{in_data[DATA_W-1]}}, in_data};
        prod = ext * ext;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sq_v_q <= 1'b0;
            sq_q   <= '0;
        end else begin
            sq_v_q <= in_valid & ~clear;
            if (in_valid && !clear) begin
                sq_q <= $unsigned(prod);
            end
        end
    end

    assign sq_valid = sq_v_q;
    assign sq_data  = sq_q;

endmodule

// File: rtl/band_power_window.sv
// band_power_window
// Windowed mean-square (band power) of the filtered sample stream over
// non-overlapping windows of 2^WIN_LOG2 samples, presented on a valid/ready
// port. Accumulation never stalls, so a pending result costs no input samples.
// Ports:
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   clear     : synchronous window restart (pending result is kept)
//   in_valid  : in_data carries a sample
//   in_data   : filtered sample, signed
//   out_valid : out_power holds an unconsumed result
//   out_ready : consumer accepts the result
//   out_power : mean square of the last completed window, unsigned
//   overrun   : sticky, a completed window was dropped while a result was pending
module band_power_window
    import filter_pkg::*;
#(
    parameter int unsigned DATA_W   = FILT_DATA_W,
    parameter int unsigned WIN_LOG2 = WIN_LOG2_DEFAULT,
    parameter int unsigned ACC_W    = acc_width(DATA_W, WIN_LOG2)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic        [2*DATA_W-1:0] out_power,
    output logic                       overrun
);

    localparam int unsigned POW_W = 2 * DATA_W;

    logic                sq_valid;
    logic [POW_W-1:0]    sq_data;

    logic [WIN_LOG2-1:0] cnt_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    sum;
    logic                win_done;
    logic                res_v_q;
    logic [POW_W-1:0]    res_q;
    logic                out_valid_q;
    logic [POW_W-1:0]    out_power_q;
    logic                overrun_q;

    sq_stage #(
        .DATA_W (DATA_W)
    ) u_sq_stage (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .sq_valid (sq_valid),
        .sq_data  (sq_data)
    );

    always_comb begin
        sum      = acc_q + {{(ACC_W - POW_W){1'b0}}, sq_data};
        // A restart takes priority over a window that would complete this cycle.
        win_done = sq_valid & (cnt_q == '1) & ~clear;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            res_v_q     <= 1'b0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            out_power_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            // Accumulate; a completed window restarts from zero in the same edge.
            if (clear) begin
                cnt_q <= '0;
                acc_q <= '0;
            end else if (sq_valid) begin
                cnt_q <= cnt_q + WIN_LOG2'(1);
                acc_q <= win_done ? '0 : sum;
            end

            // Result candidate: division by the window length is a plain shift.
            res_v_q <= win_done;
            if (win_done) begin
                res_q <= sum[WIN_LOG2 +: POW_W];
            end

            // Output register: load when free or being consumed this edge,
            // otherwise drop the new result and flag it.
            if (res_v_q) begin
                if (!out_valid_q || out_ready) begin
                    out_valid_q <= 1'b1;
                    out_power_q <= res_q;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_power = out_power_q;
    assign overrun   = overrun_q;

endmodule
